// File: rtl/array_fill_pkg.sv
// Shared types and default constants for the array fill engine.
package array_fill_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        READY = 2'd2
    } fill_state_e;

    typedef enum logic {
        MODE_DEFAULT = 1'b0,
        MODE_PATTERN = 1'b1
    } fill_mode_e;

    localparam logic [31:0] DEFAULT_VAL_RST  = 32'hFF22_3344;
    localparam logic [31:0] PATTERN_BASE_RST = 32'hFF12_0000;

    localparam logic BUSY_RST     = 1'b0;
    localparam logic DONE_RST     = 1'b0;
    localparam logic RD_VALID_RST = 1'b0;

endpackage

// File: rtl/array_fill_mem.sv
// Single-write, single registered-read word store; read-first, out-of-range reads return 0.
module array_fill_mem
    import array_fill_pkg::*;
#(
    parameter int unsigned DEPTH = 200,
    parameter int unsigned WIDTH = 32,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_d;
    logic [WIDTH-1:0] rdata_q;
    logic             wr_ok;
    logic             rd_ok;

    always_comb begin
        wr_ok = we && ({1'b0, waddr} < DEPTH_W);
        rd_ok = {1'b0, raddr} < DEPTH_W;
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Read data holds between requests; the nonblocking write makes this read-first.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = rd_ok ? mem_q[raddr] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/array_fill_engine.sv
// Fills a word array with a constant or index pattern, with host read/write access when idle.
// Pattern fill is compiled in only when ARRAY_FILL_PATTERN_EN is defined.
module array_fill_engine
    import array_fill_pkg::*;
#(
    parameter int unsigned      DEPTH        = 200,
    parameter int unsigned      WIDTH        = 32,
    parameter logic [WIDTH-1:0] DEFAULT_VAL  = WIDTH'(DEFAULT_VAL_RST),
    parameter logic [WIDTH-1:0] PATTERN_BASE = WIDTH'(PATTERN_BASE_RST)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     mode,
    output logic                     busy,
    output logic                     done,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_req,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic                     rd_valid,
    output logic [WIDTH-1:0]         rd_data
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    fill_state_e      state_q, state_d;
    logic [AW-1:0]    idx_q, idx_d;
    fill_mode_e       mode_q, mode_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             rd_valid_q, rd_valid_d;

    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic [WIDTH-1:0] mem_wdata;
    logic             mem_re;
    logic [WIDTH-1:0] fill_data;

    // Next-state and registered-output computation.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        mode_d     = mode_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        rd_valid_d = 1'b0;
        case (state_q)
            IDLE, READY: begin
                rd_valid_d = rd_req;
                if (start) begin
                    state_d = FILL;
                    idx_d   = '0;
                    busy_d  = 1'b1;
`ifdef ARRAY_FILL_PATTERN_EN
                    mode_d  = fill_mode_e'(mode);
`else
                    mode_d  = MODE_DEFAULT;
`endif
                end
            end
            FILL: begin
                if (idx_q == LAST_IDX) begin
                    state_d = READY;
                    idx_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    idx_d = idx_q + AW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

`ifdef ARRAY_FILL_PATTERN_EN
    always_comb begin
        fill_data = (mode_q == MODE_PATTERN) ? (PATTERN_BASE | WIDTH'(idx_q)) : DEFAULT_VAL;
    end
`else
    logic unused_mode;
    assign unused_mode = mode ^ mode_q;

    always_comb begin
        fill_data = DEFAULT_VAL;
    end
`endif

    // Fill owns the write port while busy; host traffic is dropped then.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = wr_addr;
        mem_wdata = wr_data;
        mem_re    = 1'b0;
        if (state_q == FILL) begin
            mem_we    = 1'b1;
            mem_waddr = idx_q;
            mem_wdata = fill_data;
        end else begin
            mem_we = wr_en;
            mem_re = rd_req;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            mode_q     <= MODE_DEFAULT;
            busy_q     <= BUSY_RST;
            done_q     <= DONE_RST;
            rd_valid_q <= RD_VALID_RST;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            mode_q     <= mode_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    array_fill_mem #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .re    (mem_re),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    assign busy     = busy_q;
    assign done     = done_q;
    assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_array_fill_engine.sv
// Directed self-checking bench for array_fill_engine (default parameters).
module tb_array_fill_engine;

`ifdef ARRAY_FILL_PATTERN_EN
    localparam logic [31:0] EXP_P0   = 32'hFF12_0000;
    localparam logic [31:0] EXP_P1   = 32'hFF12_0001;
    localparam logic [31:0] EXP_P2   = 32'hFF12_0002;
    localparam logic [31:0] EXP_P199 = 32'hFF12_00C7;
`else
    localparam logic [31:0] EXP_P0   = 32'hFF22_3344;
    localparam logic [31:0] EXP_P1   = 32'hFF22_3344;
    localparam logic [31:0] EXP_P2   = 32'hFF22_3344;
    localparam logic [31:0] EXP_P199 = 32'hFF22_3344;
`endif
    localparam logic [31:0] EXP_DEF = 32'hFF22_3344;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        mode;
    logic        busy;
    logic        done;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic        rd_req;
    logic [7:0]  rd_addr;
    logic        rd_valid;
    logic [31:0] rd_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    array_fill_engine dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .mode     (mode),
        .busy     (busy),
        .done     (done),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_req   (rd_req),
        .rd_addr  (rd_addr),
        .rd_valid (rd_valid),
        .rd_data  (rd_data)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic do_read(input string tag, input logic [7:0] addr, input logic [31:0] exp);
        rd_req  = 1'b1;
        rd_addr = addr;
        tick();
        rd_req  = 1'b0;
        chk({tag, "_valid"}, 32'(rd_valid), 32'd1);
        chk({tag, "_data"}, rd_data, exp);
    endtask

    task automatic do_write(input logic [7:0] addr, input logic [31:0] data);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic kick(input logic m);
        start = 1'b1;
        mode  = m;
        tick();
        start = 1'b0;
    endtask

    // Counts busy cycles until done; optionally re-pulses start mid-fill.
    task automatic wait_fill(input string tag, input bit poke);
        int cnt   = 0;
        int guard = 0;
        while (!done && guard < 1000) begin
            if (busy) cnt++;
            start = (poke && cnt == 100);
            if (poke && cnt == 100) mode = 1'b0;
            tick();
            guard++;
        end
        start = 1'b0;
        chk({tag, "_done_seen"}, 32'(done), 32'd1);
        chk({tag, "_busy_cycles"}, 32'(cnt), 32'd200);
        chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        tick();
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        mode    = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        rd_req  = 1'b0;
        rd_addr = '0;
        tick();
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_data", rd_data, 32'd0);
        rst = 1'b0;
        tick();

        // Host access in IDLE and rd_data hold.
        do_write(8'd10, 32'h0BAD_0010);
        do_read("idle_rd10", 8'd10, 32'h0BAD_0010);
        tick();
        chk("hold_valid", 32'(rd_valid), 32'd0);
        chk("hold_data", rd_data, 32'h0BAD_0010);

        // Constant fill.
        kick(1'b0);
        chk("fill0_busy", 32'(busy), 32'd1);
        wait_fill("fill0", 1'b0);
        do_read("m0_rd0", 8'd0, EXP_DEF);
        do_read("m0_rd1", 8'd1, EXP_DEF);
        do_read("m0_rd2", 8'd2, EXP_DEF);

        // Pattern fill from READY, with an ignored start mid-fill.
        kick(1'b1);
        wait_fill("fill1", 1'b1);
        do_read("m1_rd0", 8'd0, EXP_P0);
        do_read("m1_rd1", 8'd1, EXP_P1);
        do_read("m1_rd2", 8'd2, EXP_P2);
        do_read("m1_rd199", 8'd199, EXP_P199);

        // Same-cycle write and read to one address returns the old word.
        wr_en   = 1'b1;
        wr_addr = 8'd1;
        wr_data = 32'h0000_0002;
        rd_req  = 1'b1;
        rd_addr = 8'd1;
        tick();
        wr_en  = 1'b0;
        rd_req = 1'b0;
        chk("rf_valid", 32'(rd_valid), 32'd1);
        chk("rf_old", rd_data, EXP_P1);
        do_read("rf_new", 8'd1, 32'h0000_0002);

        // Out-of-range write dropped, read returns 0.
        do_write(8'd250, 32'h1234_5678);
        do_read("oor_rd250", 8'd250, 32'd0);

        // Reset mid-fill.
        do_write(8'd60, 32'hDEAD_0060);
        do_write(8'd10, 32'h0BAD_0010);
        kick(1'b0);
        repeat (20) tick();
        rd_req  = 1'b1;
        rd_addr = 8'd5;
        tick();
        rd_req = 1'b0;
        chk("fill_rd_valid", 32'(rd_valid), 32'd0);
        chk("fill_rd_busy", 32'(busy), 32'd1);
        repeat (29) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        begin
            logic seen_done = 1'b0;
            for (int i = 0; i < 5; i++) begin
                tick();
                seen_done |= done;
            end
            chk("midrst_no_done", 32'(seen_done), 32'd0);
        end
        do_read("midrst_rd10", 8'd10, EXP_DEF);
        do_read("midrst_rd60", 8'd60, 32'hDEAD_0060);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/array_fill_engine.md
ARRAY_FILL_ENGINE -- requirements
Module: array_fill_engine

Interface
REQ-001 SHALL have parameter DEPTH, default 200, number of storage words.
REQ-002 SHALL have parameter WIDTH, default 32, bits per word.
REQ-003 SHALL have parameter DEFAULT_VAL, default 32'hFF223344, constant fill value.
REQ-004 SHALL have parameter PATTERN_BASE, default 32'hFF120000, base OR'ed with index in pattern fill.
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port start  input  1  one-cycle fill request.
REQ-008 SHALL have port mode  input  1  0=default fill, 1=pattern fill.
REQ-009 SHALL have port busy  output  1  high while filling.
REQ-010 SHALL have port done  output  1  one-cycle pulse at fill completion.
REQ-011 SHALL have ports wr_en/wr_addr/wr_data  input  1/$clog2(DEPTH)/WIDTH  host word write.
REQ-012 SHALL have ports rd_req/rd_addr  input  1/$clog2(DEPTH)  host read request.
REQ-013 SHALL have ports rd_valid/rd_data  output  1/WIDTH  read response.

Function
REQ-014 SHALL implement FSM IDLE -> FILL on start; FILL -> READY after writing index DEPTH-1; READY -> FILL on start.
REQ-015 SHALL write one word per cycle in FILL, index 0 first, DEPTH cycles total.
REQ-016 SHALL write DEFAULT_VAL in mode 0, PATTERN_BASE | index (index zero-extended to WIDTH) in mode 1; mode sampled with start, held for the whole fill.
REQ-017 SHALL assert busy from the cycle after start through the last fill write; done pulses the cycle after the last write.
REQ-018 SHALL ignore start while in FILL.
REQ-019 SHALL drop wr_en and rd_req while busy (no rd_valid issued).
REQ-020 SHALL, in IDLE or READY, return rd_valid one cycle after rd_req with rd_data = word at rd_addr.
REQ-021 SHALL be read-first: same-cycle write and read to one address returns the old word.
REQ-022 SHALL drop writes with wr_addr >= DEPTH; reads with rd_addr >= DEPTH return rd_valid with rd_data 0.
REQ-023 SHALL hold rd_data stable when rd_valid is low.

Reset
REQ-024 SHALL on rst force state IDLE, busy 0, done 0, rd_valid 0, rd_data 0, fill index 0.
REQ-025 SHALL not clear storage on rst; rst mid-FILL abandons the fill, partially written words keep their values, no done pulse.

Configuration
REQ-026 SHALL compile pattern fill only when ARRAY_FILL_PATTERN_EN is defined; without it mode is ignored and every fill writes DEFAULT_VAL.

Structure
REQ-027 SHALL place fill-state enum (IDLE, FILL, READY), mode enum and reset-value constants in package array_fill_pkg.
REQ-028 SHALL isolate storage in sub-module array_fill_mem (1 write port, 1 registered read port, read-first).

Verification
REQ-029 SHALL check: start, mode 0 -> done after 200 busy cycles; reads of 0,1,2 -> FF223344 each.
REQ-030 SHALL check: start, mode 1 (macro on) -> reads of 0,1,2,199 -> FF120000, FF120001, FF120002, FF1200C7.
REQ-031 SHALL check: same mode-1 test with macro off -> all reads FF223344.
REQ-032 SHALL check: READY, write addr 1 = 2 and read addr 1 same cycle -> rd_data old value; next read -> 00000002.
REQ-033 SHALL check: rst at fill index 50 -> busy 0, no done; addr 10 reads filled value, addr 60 reads pre-fill value.
REQ-034 SHALL check: rd_req during FILL -> no rd_valid; rd_addr 250 in READY -> rd_valid with 0.
